// File: rtl/stop_watch_top.sv
// Minutes:seconds stopwatch with IDLE/RUNNING/PAUSED control FSM and a tick prescaler.
// Control priority on each edge is reset > stop > start. All outputs are registered.
module stop_watch_top #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       reset,
  output logic [7:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] status
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SW = 6;
  localparam int unsigned MW = 8;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUNNING = 2'b01;
  localparam logic [1:0] ST_PAUSED  = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] sec_q,   sec_d;
  logic [MW-1:0] min_q,   min_d;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
    end
  end

  // Next-state, prescaler and time-of-day update
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;

    if (reset) begin
      state_d = ST_IDLE;
      presc_d = '0;
      sec_d   = '0;
      min_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_d = '0;
          if (!stop && start) state_d = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (stop) begin
            state_d = ST_PAUSED;
          end else if (presc_q == PW'(CLK_DIV - 1)) begin
            presc_d = '0;
            if (sec_q == SW'(59)) begin
              sec_d = '0;
              min_d = (min_q == MW'(99)) ? '0 : min_q + MW'(1);
            end else begin
              sec_d = sec_q + SW'(1);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_PAUSED: begin
          if (!stop && start) state_d = ST_RUNNING;
        end
        default: begin
          state_d = ST_IDLE;
          presc_d = '0;
          sec_d   = '0;
          min_d   = '0;
        end
      endcase
    end
  end

  assign minutes = min_q;
  assign seconds = sec_q;
  assign status  = state_q;

endmodule

// File: tb/tb_stop_watch_top.sv
// Directed bench for stop_watch_top: one instance with CLK_DIV=1, one with CLK_DIV=4.
module tb_stop_watch_top;

  logic       clk;
  logic       rst_n;
  logic       start1, stop1, reset1;
  logic       start4, stop4, reset4;
  logic [7:0] minutes1, minutes4;
  logic [5:0] seconds1, seconds4;
  logic [1:0] status1,  status4;

  int n_assert = 0;
  int n_fail   = 0;

  stop_watch_top #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .reset(reset1),
    .minutes(minutes1), .seconds(seconds1), .status(status1)
  );

  stop_watch_top #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop4), .reset(reset4),
    .minutes(minutes4), .seconds(seconds4), .status(status4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk1(input string tag, input int st, input int mi, input int se);
    chk({tag, ".status"},  32'(status1),  32'(st));
    chk({tag, ".minutes"}, 32'(minutes1), 32'(mi));
    chk({tag, ".seconds"}, 32'(seconds1), 32'(se));
  endtask

  task automatic chk4(input string tag, input int st, input int mi, input int se);
    chk({tag, ".status"},  32'(status4),  32'(st));
    chk({tag, ".minutes"}, 32'(minutes4), 32'(mi));
    chk({tag, ".seconds"}, 32'(seconds4), 32'(se));
  endtask

  initial begin
    rst_n  = 1'b0;
    start1 = 1'b0; stop1 = 1'b0; reset1 = 1'b0;
    start4 = 1'b0; stop4 = 1'b0; reset4 = 1'b0;

    // Power-on reset
    #1;
    chk1("por_async", 0, 0, 0);
    chk4("por_async4", 0, 0, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk1("idle_after_reset", 0, 0, 0);

    // Start and count 20 seconds
    start1 = 1'b1; cyc(1); start1 = 1'b0;
    chk1("start_edge", 1, 0, 0);
    cyc(20);
    chk1("run20", 1, 0, 20);

    // Pause, hold, resume
    stop1 = 1'b1; cyc(1); stop1 = 1'b0;
    chk1("pause", 2, 0, 20);
    cyc(5);
    chk1("pause_hold", 2, 0, 20);
    start1 = 1'b1; cyc(1); start1 = 1'b0;
    chk1("resume_edge", 1, 0, 20);
    cyc(1);
    chk1("resume_plus1", 1, 0, 21);

    // Clear, then minute rollover and 99:59 wrap
    reset1 = 1'b1; cyc(1); reset1 = 1'b0;
    chk1("clear_running", 0, 0, 0);
    start1 = 1'b1; cyc(1); start1 = 1'b0;
    cyc(59);
    chk1("sec59", 1, 0, 59);
    cyc(1);
    chk1("min_roll", 1, 1, 0);
    cyc(5939);
    chk1("max_time", 1, 99, 59);
    cyc(1);
    chk1("wrap", 1, 0, 0);

    // Clear at 1:05, clear in IDLE, start+reset, stop+start
    cyc(65);
    chk1("at_1_05", 1, 1, 5);
    reset1 = 1'b1; cyc(1); reset1 = 1'b0;
    chk1("reset_at_1_05", 0, 0, 0);
    reset1 = 1'b1; cyc(1); reset1 = 1'b0;
    chk1("reset_idle", 0, 0, 0);
    start1 = 1'b1; reset1 = 1'b1; cyc(1); start1 = 1'b0; reset1 = 1'b0;
    chk1("start_reset_same", 0, 0, 0);
    start1 = 1'b1; cyc(1); start1 = 1'b0;
    cyc(3);
    chk1("run3", 1, 0, 3);
    stop1 = 1'b1; start1 = 1'b1; cyc(1); stop1 = 1'b0; start1 = 1'b0;
    chk1("stop_start_same", 2, 0, 3);
    stop1 = 1'b1; cyc(3);
    chk1("stop_held", 2, 0, 3);
    stop1 = 1'b0; start1 = 1'b1; cyc(3); start1 = 1'b0;
    chk1("start_held", 1, 0, 5);
    stop1 = 1'b1; cyc(1); stop1 = 1'b0;
    chk1("pause_again", 2, 0, 5);

    // CLK_DIV=4 prescaler behaviour
    chk4("div4_idle", 0, 0, 0);
    start4 = 1'b1; cyc(1); start4 = 1'b0;
    chk4("div4_start", 1, 0, 0);
    cyc(3);
    chk4("div4_pre_tick", 1, 0, 0);
    cyc(1);
    chk4("div4_first_tick", 1, 0, 1);
    cyc(4);
    chk4("div4_run8", 1, 0, 2);
    cyc(2);
    chk4("div4_mid", 1, 0, 2);
    stop4 = 1'b1; cyc(1); stop4 = 1'b0;
    chk4("div4_pause", 2, 0, 2);
    cyc(3);
    chk4("div4_pause_hold", 2, 0, 2);
    start4 = 1'b1; cyc(1); start4 = 1'b0;
    chk4("div4_resume_edge", 1, 0, 2);
    cyc(1);
    chk4("div4_resume_p1", 1, 0, 2);
    cyc(1);
    chk4("div4_resume_tick", 1, 0, 3);
    cyc(5);
    chk4("div4_more", 1, 0, 4);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk4("async_rst4", 0, 0, 0);
    chk1("async_rst1", 0, 0, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    chk4("after_async4", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
